// File: rtl/mano_pkg.sv
// mano_pkg
// Shared definitions for the Mano-style fetch/decode sequencer:
//   - state_t      : sequencer state encoding
//   - OP_BUN/OP_REG: opcode values that the sequencer treats specially
//   - IR_*         : bit positions of the I flag, opcode and address fields
package mano_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_T0_ADDR   = 3'd1,
        ST_T1_FETCH  = 3'd2,
        ST_T2_DECODE = 3'd3,
        ST_T3_INDIR  = 3'd4,
        ST_EXEC_WAIT = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_REG = 3'd7;

    // IR layout: I=[7], opcode=[6:4], address=[3:0]
    localparam int IR_I_BIT   = 7;
    localparam int IR_OP_HI   = 6;
    localparam int IR_OP_LO   = 4;
    localparam int IR_HLT_BIT = 0;

endpackage

// File: rtl/mano_instr_decode.sv
// mano_instr_decode
// Purely combinational classification of the instruction register.
// Ports:
//   i_ir          in  WORD_W  instruction register contents
//   o_is_hlt      out 1       register-reference HLT (opcode 7, I=0, bit 0 set)
//   o_is_reg      out 1       opcode 7 (register-reference / I/O group)
//   o_is_bun      out 1       opcode 4 (branch unconditionally)
//   o_is_indirect out 1       memory-reference with I=1 (needs an address fetch)
//   o_addr        out ADDR_W  address field
module mano_instr_decode
    import mano_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 8
) (
    input  logic [WORD_W-1:0] i_ir,
    output logic              o_is_hlt,
    output logic              o_is_reg,
    output logic              o_is_bun,
    output logic              o_is_indirect,
    output logic [ADDR_W-1:0] o_addr
);

    logic [2:0] w_opcode;
    logic       w_i_bit;

    assign w_opcode = i_ir[IR_OP_HI:IR_OP_LO];
    assign w_i_bit  = i_ir[IR_I_BIT];

    assign o_is_reg      = (w_opcode == OP_REG);
    // With opcode 7 the I bit selects register vs I/O group, so HLT needs I=0.
    assign o_is_hlt      = o_is_reg && !w_i_bit && i_ir[IR_HLT_BIT];
    assign o_is_bun      = (w_opcode == OP_BUN);
    // Opcode 7 never performs an indirect address fetch.
    assign o_is_indirect = w_i_bit && !o_is_reg;
    assign o_addr        = i_ir[ADDR_W-1:0];

endmodule

// File: rtl/mano_fetch_seq.sv
// mano_fetch_seq
// Instruction fetch/decode sequencer. Drives the program counter controls,
// owns AR and IR, runs the memory read handshake for instruction and
// indirect-address fetches, completes BUN and HLT locally and hands every
// other instruction to the execute unit with a one-cycle EXEC_START.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START               run request (sampled in IDLE/HALT only)
//   PC_Q                current program counter value
//   PC_INC/LD/CLR       program counter controls (mutually exclusive)
//   PC_DATA             program counter load value (0 unless PC_LD)
//   MEM_RD/MEM_ADDR     read request and address (address is always AR)
//   MEM_ACK/MEM_RDATA   read data valid / read data
//   IR, AR              instruction and address registers
//   EXEC_START          one-cycle handoff pulse to the execute unit
//   EXEC_DONE           execute unit finished
//   HALTED              high in IDLE and HALT
module mano_fetch_seq
    import mano_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] PC_Q,
    output logic              PC_INC,
    output logic              PC_LD,
    output logic              PC_CLR,
    output logic [ADDR_W-1:0] PC_DATA,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [WORD_W-1:0] MEM_RDATA,
    output logic [WORD_W-1:0] IR,
    output logic [ADDR_W-1:0] AR,
    output logic              EXEC_START,
    input  logic              EXEC_DONE,
    output logic              HALTED
);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] w_ir_next;
    logic [ADDR_W-1:0] r_ar;
    logic [ADDR_W-1:0] w_ar_next;
    // Set when an indirect fetch completes for a non-BUN instruction: the
    // first EXEC_WAIT cycle then issues EXEC_START instead of waiting.
    logic              r_exec_pend;
    logic              w_exec_pend_next;

    logic              w_is_hlt;
    logic              w_is_reg;
    logic              w_is_bun;
    logic              w_is_indirect;
    logic [ADDR_W-1:0] w_ir_addr;

    mano_instr_decode #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_decode (
        .i_ir          (r_ir),
        .o_is_hlt      (w_is_hlt),
        .o_is_reg      (w_is_reg),
        .o_is_bun      (w_is_bun),
        .o_is_indirect (w_is_indirect),
        .o_addr        (w_ir_addr)
    );

    assign IR       = r_ir;
    assign AR       = r_ar;
    assign MEM_ADDR = r_ar;
    assign HALTED   = (r_state == ST_IDLE) || (r_state == ST_HALT);

    // State, IR, AR and pending-issue registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_ir        <= {WORD_W{1'b0}};
            r_ar        <= {ADDR_W{1'b0}};
            r_exec_pend <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ir        <= w_ir_next;
            r_ar        <= w_ar_next;
            r_exec_pend <= w_exec_pend_next;
        end
    end

    // Next-state, register-update and strobe decode.
    always_comb begin
        w_next           = r_state;
        w_ir_next        = r_ir;
        w_ar_next        = r_ar;
        w_exec_pend_next = 1'b0;
        PC_INC           = 1'b0;
        PC_LD            = 1'b0;
        PC_CLR           = 1'b0;
        PC_DATA          = {ADDR_W{1'b0}};
        MEM_RD           = 1'b0;
        EXEC_START       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    PC_CLR = 1'b1;
                    w_next = ST_T0_ADDR;
                end else begin
                    w_next = ST_IDLE;
                end
            end

            ST_HALT: begin
                // Resume from the current PC; no clear.
                if (START) begin
                    w_next = ST_T0_ADDR;
                end else begin
                    w_next = ST_HALT;
                end
            end

            ST_T0_ADDR: begin
                w_ar_next = PC_Q;
                w_next    = ST_T1_FETCH;
            end

            ST_T1_FETCH: begin
                MEM_RD = 1'b1;
                if (MEM_ACK) begin
                    w_ir_next = MEM_RDATA;
                    PC_INC    = 1'b1;
                    w_next    = ST_T2_DECODE;
                end else begin
                    w_next = ST_T1_FETCH;
                end
            end

            ST_T2_DECODE: begin
                w_ar_next = w_ir_addr;
                // Priority order matters: HLT and register-reference are
                // opcode 7, which must not be mistaken for indirect.
                if (w_is_hlt) begin
                    w_next = ST_HALT;
                end else if (w_is_reg) begin
                    EXEC_START = 1'b1;
                    w_next     = ST_EXEC_WAIT;
                end else if (w_is_indirect) begin
                    w_next = ST_T3_INDIR;
                end else if (w_is_bun) begin
                    PC_LD   = 1'b1;
                    PC_DATA = w_ir_addr;
                    w_next  = ST_T0_ADDR;
                end else begin
                    EXEC_START = 1'b1;
                    w_next     = ST_EXEC_WAIT;
                end
            end

            ST_T3_INDIR: begin
                MEM_RD = 1'b1;
                if (MEM_ACK) begin
                    w_ar_next = MEM_RDATA[ADDR_W-1:0];
                    if (w_is_bun) begin
                        PC_LD   = 1'b1;
                        PC_DATA = MEM_RDATA[ADDR_W-1:0];
                        w_next  = ST_T0_ADDR;
                    end else begin
                        w_exec_pend_next = 1'b1;
                        w_next           = ST_EXEC_WAIT;
                    end
                end else begin
                    w_next = ST_T3_INDIR;
                end
            end

            ST_EXEC_WAIT: begin
                // The issue cycle after an indirect fetch is not a wait
                // cycle, so EXEC_DONE is not sampled there.
                if (r_exec_pend) begin
                    EXEC_START = 1'b1;
                    w_next     = ST_EXEC_WAIT;
                end else if (EXEC_DONE) begin
                    w_next = ST_T0_ADDR;
                end else begin
                    w_next = ST_EXEC_WAIT;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mano_fetch_seq.sv
module tb_mano_fetch_seq;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [3:0] PC_Q;
    logic       PC_INC;
    logic       PC_LD;
    logic       PC_CLR;
    logic [3:0] PC_DATA;
    logic       MEM_RD;
    logic [3:0] MEM_ADDR;
    logic       MEM_ACK;
    logic [7:0] MEM_RDATA;
    logic [7:0] IR;
    logic [3:0] AR;
    logic       EXEC_START;
    logic       EXEC_DONE;
    logic       HALTED;

    int checks   = 0;
    int failures = 0;

    // Environment: memory, handshake control and a program counter model.
    logic [7:0] mem [0:15];
    int         ack_delay;
    int         wait_cnt;
    logic       ack_block;
    logic       ack_force;
    logic       pc_preset;

    mano_fetch_seq #(.ADDR_W(4), .WORD_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .PC_Q       (PC_Q),
        .PC_INC     (PC_INC),
        .PC_LD      (PC_LD),
        .PC_CLR     (PC_CLR),
        .PC_DATA    (PC_DATA),
        .MEM_RD     (MEM_RD),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_ACK    (MEM_ACK),
        .MEM_RDATA  (MEM_RDATA),
        .IR         (IR),
        .AR         (AR),
        .EXEC_START (EXEC_START),
        .EXEC_DONE  (EXEC_DONE),
        .HALTED     (HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory responds after ack_delay wait cycles.
    always_comb begin
        MEM_ACK   = ack_force | (MEM_RD & ~ack_block & (wait_cnt >= ack_delay));
        MEM_RDATA = mem[MEM_ADDR];
    end

    // Wait-cycle counter for the memory model.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) wait_cnt <= 0;
        else if (MEM_RD && !MEM_ACK) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Program counter with INC > LD > CLR priority; unaffected by RST.
    always_ff @(posedge CLK) begin
        if (pc_preset) PC_Q <= 4'hA;
        else if (PC_INC) PC_Q <= PC_Q + 4'd1;
        else if (PC_LD) PC_Q <= PC_DATA;
        else if (PC_CLR) PC_Q <= 4'd0;
    end

    typedef struct {
        logic       start;
        logic       done;
        logic       inc;
        logic       ld;
        logic       clr;
        logic [3:0] data;
        logic       rd;
        logic [3:0] addr;
        logic       es;
        logic       halt;
        logic [7:0] ir;
        logic [3:0] ar;
        logic [3:0] pc;
    } vec_t;

    vec_t vecs [0:37];

    function automatic vec_t mk(input logic start, input logic done,
                                input logic inc, input logic ld, input logic clr,
                                input logic [3:0] data, input logic rd,
                                input logic [3:0] addr, input logic es,
                                input logic halt, input logic [7:0] ir,
                                input logic [3:0] ar, input logic [3:0] pc);
        vec_t v;
        v.start = start; v.done = done; v.inc = inc; v.ld = ld; v.clr = clr;
        v.data = data; v.rd = rd; v.addr = addr; v.es = es; v.halt = halt;
        v.ir = ir; v.ar = ar; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    int rd_cnt;
    int inc_cnt;
    int addr_bad;
    int other_pc;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'h45;  // BUN 5 direct
        mem[5]  = 8'hC6;  // BUN indirect via 6
        mem[6]  = 8'h09;
        mem[9]  = 8'h23;  // op 2 direct, address 3
        mem[10] = 8'h71;  // HLT
        mem[11] = 8'h94;  // op 1 indirect via 4
        mem[4]  = 8'h0C;
        mem[12] = 8'hF1;  // opcode 7 with I=1: register/I-O, not HLT
        mem[13] = 8'h71;  // HLT
        mem[14] = 8'h71;
        mem[15] = 8'h71;

        //            st dn inc ld clr data rd addr es hlt ir     ar    pc
        vecs[0]  = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 8'h00, 4'h0, 4'hA);
        vecs[1]  = mk(1, 0, 0, 0, 1, 4'h0, 0, 4'h0, 0, 1, 8'h00, 4'h0, 4'hA);
        vecs[2]  = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 4'h5, 0, 4'h0, 0, 0, 8'h45, 4'h0, 4'h1);
        vecs[5]  = mk(0, 1, 0, 0, 0, 4'h0, 0, 4'h5, 0, 0, 8'h45, 4'h5, 4'h5);
        vecs[6]  = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'h5, 0, 0, 8'h45, 4'h5, 4'h5);
        vecs[7]  = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h5, 0, 0, 8'hC6, 4'h5, 4'h6);
        vecs[8]  = mk(0, 0, 0, 1, 0, 4'h9, 1, 4'h6, 0, 0, 8'hC6, 4'h6, 4'h6);
        vecs[9]  = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h9, 0, 0, 8'hC6, 4'h9, 4'h9);
        vecs[10] = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'h9, 0, 0, 8'hC6, 4'h9, 4'h9);
        vecs[11] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h9, 1, 0, 8'h23, 4'h9, 4'hA);
        vecs[12] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[13] = mk(1, 0, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[14] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[15] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[16] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[17] = mk(0, 1, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[18] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h3, 0, 0, 8'h23, 4'h3, 4'hA);
        vecs[19] = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'hA, 0, 0, 8'h23, 4'hA, 4'hA);
        vecs[20] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'hA, 0, 0, 8'h71, 4'hA, 4'hB);
        vecs[21] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 0, 1, 8'h71, 4'h1, 4'hB);
        vecs[22] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 0, 1, 8'h71, 4'h1, 4'hB);
        vecs[23] = mk(1, 0, 0, 0, 0, 4'h0, 0, 4'h1, 0, 1, 8'h71, 4'h1, 4'hB);
        vecs[24] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 0, 0, 8'h71, 4'h1, 4'hB);
        vecs[25] = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'hB, 0, 0, 8'h71, 4'hB, 4'hB);
        vecs[26] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'hB, 0, 0, 8'h94, 4'hB, 4'hC);
        vecs[27] = mk(0, 0, 0, 0, 0, 4'h0, 1, 4'h4, 0, 0, 8'h94, 4'h4, 4'hC);
        vecs[28] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'hC, 1, 0, 8'h94, 4'hC, 4'hC);
        vecs[29] = mk(0, 1, 0, 0, 0, 4'h0, 0, 4'hC, 0, 0, 8'h94, 4'hC, 4'hC);
        vecs[30] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'hC, 0, 0, 8'h94, 4'hC, 4'hC);
        vecs[31] = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'hC, 0, 0, 8'h94, 4'hC, 4'hC);
        vecs[32] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'hC, 1, 0, 8'hF1, 4'hC, 4'hD);
        vecs[33] = mk(0, 1, 0, 0, 0, 4'h0, 0, 4'h1, 0, 0, 8'hF1, 4'h1, 4'hD);
        vecs[34] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 0, 0, 8'hF1, 4'h1, 4'hD);
        vecs[35] = mk(0, 0, 1, 0, 0, 4'h0, 1, 4'hD, 0, 0, 8'hF1, 4'hD, 4'hD);
        vecs[36] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'hD, 0, 0, 8'h71, 4'hD, 4'hE);
        vecs[37] = mk(0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 0, 1, 8'h71, 4'h1, 4'hE);

        RST       = 1'b1;
        START     = 1'b0;
        EXEC_DONE = 1'b0;
        ack_delay = 0;
        ack_block = 1'b0;
        ack_force = 1'b0;
        pc_preset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST       = 1'b0;
        pc_preset = 1'b0;

        // Table-driven cycle-by-cycle program run, zero-wait memory.
        for (int i = 0; i < 38; i++) begin
            START     = vecs[i].start;
            EXEC_DONE = vecs[i].done;
            @(negedge CLK);
            chk("pc_inc",     i, {7'd0, PC_INC},     {7'd0, vecs[i].inc});
            chk("pc_ld",      i, {7'd0, PC_LD},      {7'd0, vecs[i].ld});
            chk("pc_clr",     i, {7'd0, PC_CLR},     {7'd0, vecs[i].clr});
            chk("pc_data",    i, {4'd0, PC_DATA},    {4'd0, vecs[i].data});
            chk("mem_rd",     i, {7'd0, MEM_RD},     {7'd0, vecs[i].rd});
            chk("mem_addr",   i, {4'd0, MEM_ADDR},   {4'd0, vecs[i].addr});
            chk("exec_start", i, {7'd0, EXEC_START}, {7'd0, vecs[i].es});
            chk("halted",     i, {7'd0, HALTED},     {7'd0, vecs[i].halt});
            chk("ir",         i, IR,                 vecs[i].ir);
            chk("ar",         i, {4'd0, AR},         {4'd0, vecs[i].ar});
            chk("pc_q",       i, {4'd0, PC_Q},       {4'd0, vecs[i].pc});
            next_cycle();
        end
        START     = 1'b0;
        EXEC_DONE = 1'b0;

        // Three wait cycles in T1: RD held 4 cycles, stable address, one INC.
        ack_delay = 3;
        START = 1'b1;
        @(negedge CLK);
        chk("resume_no_clr", 100, {7'd0, PC_CLR}, 8'd0);
        next_cycle();
        START    = 1'b0;
        rd_cnt   = 0;
        inc_cnt  = 0;
        addr_bad = 0;
        other_pc = 0;
        repeat (8) begin
            @(negedge CLK);
            if (MEM_RD) rd_cnt++;
            if (MEM_RD && MEM_ADDR !== 4'hE) addr_bad++;
            if (PC_INC) inc_cnt++;
            if (PC_LD || PC_CLR) other_pc++;
            next_cycle();
        end
        @(negedge CLK);
        chk("wait_rd_cycles",  101, rd_cnt[7:0],   8'd4);
        chk("wait_addr_stable",101, addr_bad[7:0], 8'd0);
        chk("wait_inc_count",  101, inc_cnt[7:0],  8'd1);
        chk("wait_no_ld_clr",  101, other_pc[7:0], 8'd0);
        chk("wait_halted",     101, {7'd0, HALTED}, 8'd1);
        chk("wait_pc",         101, {4'd0, PC_Q},   8'h0F);

        // Fetch at address 15: PC wraps to 0.
        next_cycle();
        ack_delay = 0;
        START = 1'b1;
        next_cycle();
        START = 1'b0;
        repeat (4) next_cycle();
        @(negedge CLK);
        chk("wrap_pc",     102, {4'd0, PC_Q},   8'h00);
        chk("wrap_halted", 102, {7'd0, HALTED}, 8'd1);
        chk("wrap_ir",     102, IR,             8'h71);

        // Reset asserted while waiting in T3_INDIR.
        mem[0] = 8'hA6;  // op 2 indirect via 6
        next_cycle();
        START = 1'b1;
        next_cycle();     // T0
        START = 1'b0;
        next_cycle();     // T1
        next_cycle();     // T2
        ack_block = 1'b1;
        next_cycle();     // T3, ack withheld
        @(negedge CLK);
        chk("indir_rd",   103, {7'd0, MEM_RD}, 8'd1);
        chk("indir_addr", 103, {4'd0, MEM_ADDR}, 8'h06);
        #1;
        RST = 1'b1;
        #1;
        chk("rst_rd",     104, {7'd0, MEM_RD}, 8'd0);
        chk("rst_halted", 104, {7'd0, HALTED}, 8'd1);
        chk("rst_ir",     104, IR,             8'h00);
        chk("rst_ar",     104, {4'd0, AR},     8'h00);
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        ack_block = 1'b0;
        ack_force = 1'b1;
        @(negedge CLK);
        chk("late_ack_rd",  105, {7'd0, MEM_RD}, 8'd0);
        chk("late_ack_clr", 105, {7'd0, PC_CLR}, 8'd0);
        next_cycle();
        ack_force = 1'b0;
        @(negedge CLK);
        chk("late_ack_halted", 106, {7'd0, HALTED}, 8'd1);
        chk("late_ack_ir",     106, IR,             8'h00);
        chk("late_ack_ar",     106, {4'd0, AR},     8'h00);
        chk("late_ack_inc",    106, {7'd0, PC_INC}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
